// File: rtl/req_mem_arb.sv
// Two-master (CPU, VGA) to one-slave burst arbiter: grants a whole burst per
// arbitration round with round-robin on ties, then routes that burst's beats.
module req_mem_arb #(
    parameter int LW = 3
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          cpu_req_valid,
    output logic          cpu_req_ready,
    input  logic [LW-1:0] cpu_req_len,
    input  logic [3:0]    cpu_req_mask,
    input  logic [31:0]   cpu_req_addr,
    input  logic          cpu_req_we,
    input  logic          cpu_req_wrap,
    input  logic          cpu_write_valid,
    input  logic [31:0]   cpu_write_data,
    output logic          cpu_read_valid,
    output logic [31:0]   cpu_read_data,
    input  logic          cpu_read_ack,

    input  logic          vga_req_valid,
    output logic          vga_req_ready,
    input  logic [LW-1:0] vga_req_len,
    input  logic [3:0]    vga_req_mask,
    input  logic [31:0]   vga_req_addr,
    input  logic          vga_req_we,
    input  logic          vga_req_wrap,
    input  logic          vga_write_valid,
    input  logic [31:0]   vga_write_data,
    output logic          vga_read_valid,
    output logic [31:0]   vga_read_data,
    input  logic          vga_read_ack,

    output logic          mem_req_valid,
    input  logic          mem_req_ready,
    output logic [LW-1:0] mem_req_len,
    output logic [3:0]    mem_req_mask,
    output logic [31:0]   mem_req_addr,
    output logic          mem_req_we,
    output logic          mem_req_wrap,
    output logic          mem_write_valid,
    output logic [31:0]   mem_write_data,
    input  logic          mem_read_valid,
    input  logic [31:0]   mem_read_data,
    output logic          mem_read_ack
);

    typedef enum logic [1:0] {IDLE, REQ, WDATA, RDATA} state_t;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_VGA = 1'b1;

    state_t        state_q, state_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic [LW-1:0] len_q, len_d;
    logic [3:0]    mask_q, mask_d;
    logic [31:0]   addr_q, addr_d;
    logic          we_q, we_d;
    logic          wrap_q, wrap_d;

    logic          pick;
    logic          wrBeat;
    logic          rdBeat;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            owner_q <= OWN_CPU;
            last_q  <= OWN_VGA;
            len_q   <= '0;
            mask_q  <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            len_q   <= len_d;
            mask_q  <= mask_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wrap_q  <= wrap_d;
        end
    end

    // On a tie the master that did not win last time goes next.
    always_comb begin
        pick = OWN_CPU;
        if (cpu_req_valid && vga_req_valid) begin
            pick = ~last_q;
        end else if (vga_req_valid) begin
            pick = OWN_VGA;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        last_d  = last_q;
        len_d   = len_q;
        mask_d  = mask_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wrap_d  = wrap_q;
        case (state_q)
            IDLE: begin
                if (cpu_req_valid || vga_req_valid) begin
                    owner_d = pick;
                    last_d  = pick;
                    state_d = REQ;
                    if (pick == OWN_VGA) begin
                        len_d  = vga_req_len;
                        mask_d = vga_req_mask;
                        addr_d = vga_req_addr;
                        we_d   = vga_req_we;
                        wrap_d = vga_req_wrap;
                    end else begin
                        len_d  = cpu_req_len;
                        mask_d = cpu_req_mask;
                        addr_d = cpu_req_addr;
                        we_d   = cpu_req_we;
                        wrap_d = cpu_req_wrap;
                    end
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    cnt_d   = len_q;
                    state_d = we_q ? WDATA : RDATA;
                end
            end
            WDATA: begin
                if (wrBeat) begin
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - LW'(1);
                    end
                end
            end
            RDATA: begin
                if (rdBeat) begin
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - LW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Beat routing is purely combinational so the owner sees the slave with no added latency.
    always_comb begin
        mem_req_valid   = 1'b0;
        cpu_req_ready   = 1'b0;
        vga_req_ready   = 1'b0;
        mem_write_valid = 1'b0;
        mem_write_data  = '0;
        mem_read_ack    = 1'b0;
        cpu_read_valid  = 1'b0;
        cpu_read_data   = '0;
        vga_read_valid  = 1'b0;
        vga_read_data   = '0;
        case (state_q)
            REQ: begin
                mem_req_valid = 1'b1;
                cpu_req_ready = (owner_q == OWN_CPU) && mem_req_ready;
                vga_req_ready = (owner_q == OWN_VGA) && mem_req_ready;
            end
            WDATA: begin
                mem_write_valid = (owner_q == OWN_VGA) ? vga_write_valid : cpu_write_valid;
                mem_write_data  = (owner_q == OWN_VGA) ? vga_write_data  : cpu_write_data;
            end
            RDATA: begin
                mem_read_ack = (owner_q == OWN_VGA) ? vga_read_ack : cpu_read_ack;
                if (owner_q == OWN_VGA) begin
                    vga_read_valid = mem_read_valid;
                    vga_read_data  = mem_read_data;
                end else begin
                    cpu_read_valid = mem_read_valid;
                    cpu_read_data  = mem_read_data;
                end
            end
            default: ;
        endcase
    end

    assign wrBeat = mem_write_valid;
    assign rdBeat = mem_read_valid && mem_read_ack;

    assign mem_req_len  = len_q;
    assign mem_req_mask = mask_q;
    assign mem_req_addr = addr_q;
    assign mem_req_we   = we_q;
    assign mem_req_wrap = wrap_q;

endmodule

// File: tb/tb_req_mem_arb.sv
// Scoreboard bench for req_mem_arb: directed reset/tie/latency checks, then
// randomized bursts from both masters checked against a grant-order model.
module tb_req_mem_arb;

    typedef struct packed {
        logic [2:0]  len;
        logic [3:0]  mask;
        logic [31:0] addr;
        logic        we;
        logic        wrap;
        logic [31:0] wbase;
        logic        who;
    } burst_t;

    logic clk = 1'b0;
    logic rst;

    logic        reqValid[2];
    logic        reqReady[2];
    logic [2:0]  reqLen[2];
    logic [3:0]  reqMask[2];
    logic [31:0] reqAddr[2];
    logic        reqWe[2];
    logic        reqWrap[2];
    logic        writeValid[2];
    logic [31:0] writeData[2];
    logic        readValid[2];
    logic [31:0] readData[2];
    logic        readAck[2];

    logic        memReqValid, memReqReady;
    logic [2:0]  memReqLen;
    logic [3:0]  memReqMask;
    logic [31:0] memReqAddr;
    logic        memReqWe, memReqWrap;
    logic        memWriteValid;
    logic [31:0] memWriteData;
    logic        memReadValid;
    logic [31:0] memReadData;
    logic        memReadAck;

    burst_t      expReq[$];
    burst_t      slvQ[$];
    logic [31:0] expWr[$];
    logic [31:0] expRd0[$];
    logic [31:0] expRd1[$];

    int compared   = 0;
    int mismatched = 0;
    logic lastGrant;

    always #5 clk = ~clk;

    req_mem_arb #(.LW(3)) dut (
        .clk(clk), .rst(rst),
        .cpu_req_valid(reqValid[0]), .cpu_req_ready(reqReady[0]), .cpu_req_len(reqLen[0]),
        .cpu_req_mask(reqMask[0]), .cpu_req_addr(reqAddr[0]), .cpu_req_we(reqWe[0]),
        .cpu_req_wrap(reqWrap[0]), .cpu_write_valid(writeValid[0]), .cpu_write_data(writeData[0]),
        .cpu_read_valid(readValid[0]), .cpu_read_data(readData[0]), .cpu_read_ack(readAck[0]),
        .vga_req_valid(reqValid[1]), .vga_req_ready(reqReady[1]), .vga_req_len(reqLen[1]),
        .vga_req_mask(reqMask[1]), .vga_req_addr(reqAddr[1]), .vga_req_we(reqWe[1]),
        .vga_req_wrap(reqWrap[1]), .vga_write_valid(writeValid[1]), .vga_write_data(writeData[1]),
        .vga_read_valid(readValid[1]), .vga_read_data(readData[1]), .vga_read_ack(readAck[1]),
        .mem_req_valid(memReqValid), .mem_req_ready(memReqReady), .mem_req_len(memReqLen),
        .mem_req_mask(memReqMask), .mem_req_addr(memReqAddr), .mem_req_we(memReqWe),
        .mem_req_wrap(memReqWrap), .mem_write_valid(memWriteValid), .mem_write_data(memWriteData),
        .mem_read_valid(memReadValid), .mem_read_data(memReadData), .mem_read_ack(memReadAck)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Grant order follows the round-robin rule; the slave and monitors consume it.
    task automatic modelPush(input burst_t b);
        expReq.push_back(b);
        slvQ.push_back(b);
        if (b.we) begin
            for (int k = 0; k <= int'(b.len); k++) expWr.push_back(b.wbase + 32'(k));
        end
    endtask

    task automatic applyStimulus(input burst_t b);
        int w = int'(b.who);
        int guard = 0;
        int got = 0;
        reqValid[w] = 1'b1;
        reqLen[w]   = b.len;
        reqMask[w]  = b.mask;
        reqAddr[w]  = b.addr;
        reqWe[w]    = b.we;
        reqWrap[w]  = b.wrap;
        @(negedge clk);
        while (!reqReady[w] && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        if (!reqReady[w]) begin
            checkOutput("req handshake timeout", 64'd0, 64'd1);
            reqValid[w] = 1'b0;
            return;
        end
        tick();
        reqValid[w] = 1'b0;
        reqAddr[w]  = $urandom;
        reqLen[w]   = 3'($urandom);
        if (b.we) begin
            for (int k = 0; k <= int'(b.len); k++) begin
                repeat ($urandom_range(0, 1)) begin
                    writeValid[w] = 1'b0;
                    tick();
                end
                writeValid[w] = 1'b1;
                writeData[w]  = b.wbase + 32'(k);
                tick();
            end
            writeValid[w] = 1'b0;
        end else begin
            guard = 0;
            while (got <= int'(b.len) && guard < 400) begin
                readAck[w] = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                if (readValid[w] && readAck[w]) got++;
                tick();
                guard++;
            end
            readAck[w] = 1'b0;
            if (got <= int'(b.len)) checkOutput("read beats timeout", 64'(got), 64'(b.len) + 64'd1);
        end
    endtask

    task automatic slaveLoop();
        burst_t e;
        int guard;
        logic [31:0] d;
        forever begin
            @(negedge clk);
            if (memReqValid && slvQ.size() > 0) begin
                repeat ($urandom_range(0, 5)) tick();
                @(posedge clk);
                #1 memReqReady = 1'b1;
                @(negedge clk);
                tick();
                memReqReady = 1'b0;
                e = slvQ.pop_front();
                if (!e.we) begin
                    for (int k = 0; k <= int'(e.len); k++) begin
                        repeat ($urandom_range(0, 2)) tick();
                        d = $urandom;
                        memReadValid = 1'b1;
                        memReadData  = d;
                        if (e.who) expRd1.push_back(d);
                        else       expRd0.push_back(d);
                        guard = 0;
                        @(negedge clk);
                        while (!memReadAck && guard < 200) begin
                            @(negedge clk);
                            guard++;
                        end
                        if (!memReadAck) checkOutput("mem_read_ack timeout", 64'd0, 64'd1);
                        tick();
                        memReadValid = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic monitorLoop();
        burst_t e;
        logic [31:0] ew;
        forever begin
            @(negedge clk);
            if (memReqValid) begin
                if (expReq.size() == 0) begin
                    checkOutput("unexpected mem_req_valid", 64'd1, 64'd0);
                end else begin
                    e = expReq[0];
                    checkOutput("mem_req fields",
                        64'({memReqLen, memReqMask, memReqAddr, memReqWe, memReqWrap}),
                        64'({e.len, e.mask, e.addr, e.we, e.wrap}));
                    checkOutput("req_ready routing", 64'({reqReady[0], reqReady[1]}),
                        64'({memReqReady && !e.who, memReqReady && e.who}));
                    if (memReqReady) void'(expReq.pop_front());
                end
            end
            if (memWriteValid) begin
                if (expWr.size() == 0) begin
                    checkOutput("unexpected write beat", 64'(memWriteData), 64'd0);
                end else begin
                    ew = expWr.pop_front();
                    checkOutput("write beat data", 64'(memWriteData), 64'(ew));
                end
            end
            if (readValid[0] || readValid[1])
                checkOutput("read_valid exclusive", 64'(readValid[0] && readValid[1]), 64'd0);
            if (readValid[0] && readAck[0]) begin
                if (expRd0.size() == 0) checkOutput("unexpected cpu read beat", 64'd1, 64'd0);
                else begin
                    ew = expRd0.pop_front();
                    checkOutput("cpu read data", 64'(readData[0]), 64'(ew));
                end
            end
            if (readValid[1] && readAck[1]) begin
                if (expRd1.size() == 0) checkOutput("unexpected vga read beat", 64'd1, 64'd0);
                else begin
                    ew = expRd1.pop_front();
                    checkOutput("vga read data", 64'(readData[1]), 64'(ew));
                end
            end
        end
    endtask

    function automatic burst_t randBurst(input logic who);
        burst_t b;
        b.len   = 3'($urandom_range(0, 7));
        b.mask  = 4'($urandom);
        b.addr  = $urandom;
        b.we    = 1'($urandom_range(0, 1));
        b.wrap  = 1'($urandom_range(0, 1));
        b.wbase = $urandom;
        b.who   = who;
        return b;
    endfunction

    initial begin
        burst_t bc, bv;
        logic [1:0] pattern;
        logic first;

        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            reqValid[i] = 0; reqLen[i] = 0; reqMask[i] = 0; reqAddr[i] = 0;
            reqWe[i] = 0; reqWrap[i] = 0; writeValid[i] = 0; writeData[i] = 0; readAck[i] = 0;
        end
        memReqReady  = 1'b0;
        memReadValid = 1'b1;
        memReadData  = 32'hDEAD;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        @(negedge clk);
        checkOutput("reset ctrl outputs",
            64'({memReqValid, memWriteValid, memReadAck, reqReady[0], reqReady[1], readValid[0], readValid[1]}), 64'd0);
        checkOutput("reset cpu_read_data", 64'(readData[0]), 64'd0);
        checkOutput("reset vga_read_data", 64'(readData[1]), 64'd0);
        checkOutput("reset mem_req fields", 64'({memReqLen, memReqMask, memReqAddr, memReqWe, memReqWrap}), 64'd0);
        checkOutput("reset mem_write_data", 64'(memWriteData), 64'd0);

        tick();
        memReadValid = 1'b0;
        reqValid[0] = 1; reqLen[0] = 3'd5; reqWe[0] = 1; reqAddr[0] = 32'h2000; reqMask[0] = 4'hF;
        reqValid[1] = 1; reqLen[1] = 3'd2; reqWe[1] = 0; reqAddr[1] = 32'h3000; reqMask[1] = 4'h3;
        @(negedge clk);
        checkOutput("no req in grant cycle", 64'(memReqValid), 64'd0);
        tick();
        @(negedge clk);
        checkOutput("req valid one cycle later", 64'(memReqValid), 64'd1);
        checkOutput("first tie grants cpu", 64'({memReqLen, memReqAddr, memReqWe}), 64'({3'd5, 32'h2000, 1'b1}));
        checkOutput("ready low while stalled", 64'({reqReady[0], reqReady[1]}), 64'd0);
        tick();
        memReqReady = 1'b1;
        @(negedge clk);
        checkOutput("cpu req_ready", 64'({reqReady[0], reqReady[1]}), 64'b10);
        tick();
        memReqReady = 1'b0; reqValid[0] = 0; writeValid[0] = 1; writeData[0] = 32'h500;
        @(negedge clk);
        checkOutput("write beat 0", 64'({memWriteValid, memWriteData}), 64'({1'b1, 32'h500}));
        tick();
        writeData[0] = 32'h501;
        @(negedge clk);
        checkOutput("write beat 1", 64'({memWriteValid, memWriteData}), 64'({1'b1, 32'h501}));
        #2 rst = 1'b0;
        #1;
        checkOutput("async reset mid-burst",
            64'({memReqValid, memWriteValid, memReadAck, reqReady[0], reqReady[1], readValid[0], readValid[1], memReqAddr}), 64'd0);
        writeValid[0] = 0;
        reqValid[0] = 1; reqWe[0] = 0; reqLen[0] = 3'd0; reqAddr[0] = 32'h4000;
        tick();
        rst = 1'b1;
        @(negedge clk);
        checkOutput("idle after reset release", 64'(memReqValid), 64'd0);
        tick();
        @(negedge clk);
        checkOutput("tie after reset grants cpu", 64'({memReqValid, memReqAddr}), 64'({1'b1, 32'h4000}));
        tick();
        memReqReady = 1'b1;
        @(negedge clk);
        checkOutput("cpu req_ready after reset", 64'({reqReady[0], reqReady[1]}), 64'b10);
        tick();
        memReqReady = 1'b0; reqValid[0] = 0; memReadValid = 1; memReadData = 32'h77; readAck[0] = 1;
        @(negedge clk);
        checkOutput("read routing", 64'({readValid[0], readValid[1], memReadAck}), 64'b101);
        checkOutput("cpu read data direct", 64'(readData[0]), 64'h77);
        checkOutput("vga read data zero", 64'(readData[1]), 64'd0);
        tick();
        memReadValid = 0; readAck[0] = 0; reqValid[1] = 0;
        @(negedge clk);
        checkOutput("idle after single-beat read", 64'({memReqValid, memReadAck}), 64'd0);
        lastGrant = 1'b0;
        tick();

        fork
            slaveLoop();
            monitorLoop();
        join_none

        for (int r = 0; r < 40; r++) begin
            pattern = 2'($urandom_range(1, 3));
            if (r < 6) pattern = 2'b11;
            bc = randBurst(1'b0);
            bv = randBurst(1'b1);
            if (pattern == 2'b11) begin
                first = ~lastGrant;
                modelPush(first ? bv : bc);
                modelPush(first ? bc : bv);
                lastGrant = ~first;
            end else begin
                modelPush(pattern[1] ? bv : bc);
                lastGrant = pattern[1];
            end
            fork
                begin if (pattern[0]) applyStimulus(bc); end
                begin if (pattern[1]) applyStimulus(bv); end
            join
            repeat (2) tick();
        end

        repeat (10) tick();
        checkOutput("request queue drained", 64'(expReq.size()), 64'd0);
        checkOutput("write queue drained", 64'(expWr.size()), 64'd0);
        checkOutput("cpu read queue drained", 64'(expRd0.size()), 64'd0);
        checkOutput("vga read queue drained", 64'(expRd1.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
